rle_stream_encoder: RTL and testbench

//  Parametrised streaming run-length encoder core; successor to the fixed-width, register-driven RLE encoder IP.

---
 rtl/rle_stream_encoder.sv | 121 ++++++++++++
 tb/tb_rle_stream_encoder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_stream_encoder.sv
// rtl/rle_stream_encoder.sv - streaming run-length encoder with TLAST framing, saturation and statistics
module rle_stream_encoder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter int STAT_W = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [DATA_W-1:0]       s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [CNT_W+DATA_W-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  input  logic                    clear_stats,
  output logic [STAT_W-1:0]       beats_in,
  output logic [STAT_W-1:0]       tokens_out
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [CNT_W-1:0] MAX_RUN = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t            state;
  logic [DATA_W-1:0] run_sym;
  logic [DATA_W-1:0] pend_sym;
  logic [CNT_W-1:0]  run_cnt;
  logic              out_free;
  logic              acc;
  logic              extend;

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = out_free && (state != FLUSH) && !ARESET;
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign extend        = (s_axis_tdata == run_sym) && (run_cnt != MAX_RUN);

  // Every emission is gated by out_free (acc implies it), so a stalled token never changes.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= IDLE;
      run_sym       <= '0;
      run_cnt       <= '0;
      pend_sym      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (out_free) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (acc) begin
            if (s_axis_tlast) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= {ONE, s_axis_tdata};
              m_axis_tlast  <= 1'b1;
            end else begin
              run_sym <= s_axis_tdata;
              run_cnt <= ONE;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (acc) begin
            if (extend) begin
              if (s_axis_tlast) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= {run_cnt + ONE, run_sym};
                m_axis_tlast  <= 1'b1;
                state         <= IDLE;
              end else begin
                run_cnt <= run_cnt + ONE;
              end
            end else begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= {run_cnt, run_sym};
              m_axis_tlast  <= 1'b0;
              if (s_axis_tlast) begin
                pend_sym <= s_axis_tdata;
                state    <= FLUSH;
              end else begin
                run_sym <= s_axis_tdata;
                run_cnt <= ONE;
              end
            end
          end
        end
        FLUSH: begin
          // The closing single-symbol token waits here for the output slot to free up.
          if (out_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {ONE, pend_sym};
            m_axis_tlast  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || clear_stats) begin
      beats_in   <= '0;
      tokens_out <= '0;
    end else begin
      if (acc) begin
        beats_in <= beats_in + STAT_W'(1);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        tokens_out <= tokens_out + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rle_stream_encoder.sv
// tb/tb_rle_stream_encoder.sv - scoreboard bench for rle_stream_encoder (DATA_W=8, CNT_W=4)
module tb_rle_stream_encoder;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam int SW = 32;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [CW+DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          clear_stats = 1'b0;
  logic [SW-1:0] beats_in;
  logic [SW-1:0] tokens_out;

  always #5 ACLK = ~ACLK;

  rle_stream_encoder #(.DATA_W(DW), .CNT_W(CW), .STAT_W(SW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .clear_stats(clear_stats), .beats_in(beats_in), .tokens_out(tokens_out)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [12:0] exp_q[$];
  logic [7:0]  pkt[$];
  int          tready_mode = 0;
  bit          rand_valid = 1'b0;
  logic        prev_stall = 1'b0;
  logic [12:0] prev_tok = '0;

  function automatic logic [12:0] tok(input logic [3:0] c, input logic [7:0] s, input logic l);
    return {l, c, s};
  endfunction

  // Downstream ready pattern: 0 = always ready, 1 = toggle each cycle, 2 = random.
  initial forever begin
    @(posedge ACLK);
    #1;
    case (tready_mode)
      1:       m_axis_tready = ~m_axis_tready;
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b1;
    endcase
  end

  // Output monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge ACLK) begin
    logic [12:0] got;
    logic [12:0] exp;
    got = {m_axis_tlast, m_axis_tdata};
    if (ARESET) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || got !== prev_tok) begin
          n_fail++;
          $display("FAIL stall_stable: got valid=%0b tok=%h, required valid=1 tok=%h", m_axis_tvalid, got, prev_tok);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_token: got tok=%h, required none", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL token: got {last,cnt,sym}=%h, required %h", got, exp);
          end
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_tok = got;
    end
  end

  task automatic send_pkt();
    int i = 0;
    int guard = 0;
    while (i < pkt.size() && guard < 1000) begin
      if (!s_axis_tvalid) s_axis_tvalid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tdata = pkt[i];
      s_axis_tlast = (i == pkt.size() - 1);
      @(negedge ACLK);
      if (s_axis_tvalid && s_axis_tready) begin
        i++;
        @(posedge ACLK);
        #1;
        s_axis_tvalid = 1'b0;
      end else begin
        @(posedge ACLK);
        #1;
      end
      guard++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    n_checks++;
    if (i != pkt.size()) begin
      n_fail++;
      $display("FAIL send_timeout: got %0d beats accepted, required %0d", i, pkt.size());
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (!(exp_q.size() == 0 && !m_axis_tvalid) && guard < 500) begin
      @(negedge ACLK);
      guard++;
    end
    n_checks++;
    if (exp_q.size() != 0 || m_axis_tvalid) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d tokens outstanding, required 0", exp_q.size());
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic model_push();
    logic [7:0] cur;
    int cnt;
    cur = pkt[0];
    cnt = 1;
    for (int k = 1; k < pkt.size(); k++) begin
      if (pkt[k] == cur && cnt < 15) begin
        cnt++;
      end else begin
        exp_q.push_back(tok(4'(cnt), cur, 1'b0));
        cur = pkt[k];
        cnt = 1;
      end
    end
    exp_q.push_back(tok(4'(cnt), cur, 1'b1));
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0 || s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b d=%h l=%0b rdy=%0b, required 0 0 0 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready);
    end
    n_checks++;
    if (beats_in !== '0 || tokens_out !== '0) begin
      n_fail++;
      $display("FAIL reset_stats: got beats=%0d tokens=%0d, required 0 0", beats_in, tokens_out);
    end
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_basic();
    pkt = '{8'hAA, 8'hAA, 8'hAA, 8'hBB};
    exp_q.push_back(tok(4'd3, 8'hAA, 1'b0));
    exp_q.push_back(tok(4'd1, 8'hBB, 1'b1));
    send_pkt();
    @(negedge ACLK);
    n_checks++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_bubble: got s_tready=%0b, required 0", s_axis_tready);
    end
    wait_drain();
    n_checks++;
    if (beats_in !== 32'd4 || tokens_out !== 32'd2) begin
      n_fail++;
      $display("FAIL basic_stats: got beats=%0d tokens=%0d, required 4 2", beats_in, tokens_out);
    end
  endtask

  task automatic test_saturation();
    pkt.delete();
    repeat (20) pkt.push_back(8'h55);
    exp_q.push_back(tok(4'd15, 8'h55, 1'b0));
    exp_q.push_back(tok(4'd5, 8'h55, 1'b1));
    send_pkt();
    wait_drain();
    pkt.delete();
    repeat (16) pkt.push_back(8'h55);
    exp_q.push_back(tok(4'd15, 8'h55, 1'b0));
    exp_q.push_back(tok(4'd1, 8'h55, 1'b1));
    send_pkt();
    wait_drain();
  endtask

  task automatic test_single();
    pkt = '{8'h7E};
    exp_q.push_back(tok(4'd1, 8'h7E, 1'b1));
    send_pkt();
    @(negedge ACLK);
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_no_bubble: got s_tready=%0b, required 1", s_axis_tready);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    tready_mode = 1;
    rand_valid = 1'b1;
    pkt = '{8'hAA, 8'hAA, 8'hAA, 8'hBB};
    exp_q.push_back(tok(4'd3, 8'hAA, 1'b0));
    exp_q.push_back(tok(4'd1, 8'hBB, 1'b1));
    send_pkt();
    wait_drain();
    tready_mode = 2;
    for (int p = 0; p < 4; p++) begin
      pkt.delete();
      repeat ($urandom_range(1, 40)) pkt.push_back(($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00);
      model_push();
      send_pkt();
    end
    wait_drain();
    tready_mode = 0;
    rand_valid = 1'b0;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset_flush();
    pkt = '{8'h01, 8'h02};
    send_pkt();
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    n_checks++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop_valid: got m_tvalid=%0b, required 0", m_axis_tvalid);
    end
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    pkt = '{8'h09};
    exp_q.push_back(tok(4'd1, 8'h09, 1'b1));
    send_pkt();
    wait_drain();
  endtask

  task automatic test_clear_stats();
    exp_q.push_back(tok(4'd1, 8'h33, 1'b1));
    exp_q.push_back(tok(4'd1, 8'h44, 1'b1));
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 8'h33;
    s_axis_tlast = 1'b1;
    clear_stats = 1'b1;
    @(negedge ACLK);
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_accept: got s_tready=%0b, required 1", s_axis_tready);
    end
    @(posedge ACLK);
    #1;
    clear_stats = 1'b0;
    s_axis_tdata = 8'h44;
    @(negedge ACLK);
    n_checks++;
    if (beats_in !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_wins: got beats=%0d, required 0", beats_in);
    end
    @(posedge ACLK);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    wait_drain();
    n_checks++;
    if (beats_in !== 32'd1 || tokens_out !== 32'd2) begin
      n_fail++;
      $display("FAIL clear_resume: got beats=%0d tokens=%0d, required 1 2", beats_in, tokens_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_single();
    test_backpressure();
    test_reset_flush();
    test_clear_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
